// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed data_mem; sub-word stores use read-modify-write.
// Optional MEM_BOUNDS_CHECK_EN: word index beyond DEPTH raises resp_err instead of wrapping.
module load_store_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t     state;
  logic       op_we;
  logic [1:0] op_size;
  logic       op_unsigned;
  logic [1:0] op_lane;
  logic       req_err;
  logic       accept;

  // Replace only the addressed byte/half of the old word.
  function automatic logic [N-1:0] merge_word(input logic [N-1:0] old_word,
                                              input logic [N-1:0] wdata,
                                              input logic [1:0]   size,
                                              input logic [1:0]   lane);
    logic [N-1:0] merged;
    merged = old_word;
    if (size == 2'b00)
      merged[{lane, 3'b000} +: 8] = wdata[7:0];
    else
      merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    return merged;
  endfunction

  function automatic logic [N-1:0] extend_load(input logic [N-1:0] rdata,
                                               input logic [1:0]   size,
                                               input logic         uns,
                                               input logic [1:0]   lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return uns ? {{(N-8){1'b0}}, b}  : {{(N-8){b[7]}}, b};
      2'b01:   return uns ? {{(N-16){1'b0}}, h} : {{(N-16){h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b11:   req_err = 1'b1;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b0;
    endcase
`ifdef MEM_BOUNDS_CHECK_EN
    if (|req_addr[N-1:AW+2]) req_err = 1'b1;
`endif
  end

`ifndef MEM_BOUNDS_CHECK_EN
  // Upper address bits are intentionally dropped: the index wraps modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr[N-1:AW+2];
`endif

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      op_we       <= 1'b0;
      op_size     <= 2'b00;
      op_unsigned <= 1'b0;
      op_lane     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_we       <= req_we;
            op_size     <= req_size;
            op_unsigned <= req_unsigned;
            op_lane     <= req_addr[1:0];
            mem_addr    <= {{(N-AW){1'b0}}, req_addr[AW+1:2]};
            mem_wdata   <= req_wdata;
            req_ready   <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && req_size == 2'b10) begin
              state  <= WR;
              mem_we <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        // Old word sampled here: either load data or the base for a sub-word merge.
        RD: begin
          if (op_we) begin
            mem_wdata <= merge_word(mem_rdata, mem_wdata, op_size, op_lane);
            mem_we    <= 1'b1;
            state     <= WR;
          end else begin
            resp_rdata <= extend_load(mem_rdata, op_size, op_unsigned, op_lane);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          mem_we     <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data_mem (combinational read, clocked write).
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [32];
  logic        init_done = 1'b0;

  int checks = 0;
  int errors = 0;

  int          lat, we_cnt, we_at;
  logic [31:0] addr_seen;
  logic        saw_resp;

  always #5 clk = ~clk;

  load_store_unit #(.N(32), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (!init_done) begin
      for (int k = 0; k < 32; k++)
        mem[k] <= (k < 6) ? 32'(k + 1) : (k < 12) ? 32'(k - 5) : 32'd0;
      init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[4:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request; lat = negedge index (1 = first after accept) where resp_valid is seen, 0 on timeout.
  task automatic run(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output int l, output int wc, output int wa, output logic [31:0] as);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    l = 0; wc = 0; wa = 0; as = mem_addr;
    for (int k = 1; k <= 8; k++) begin
      if (mem_we) begin wc++; wa = k; end
      if (resp_valid) begin l = k; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    run(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, lat, we_cnt, we_at, addr_seen);
    check("lw4_lat", lat, 32'd2);
    check("lw4_rdata", resp_rdata, 32'h00000002);
    check("lw4_err", {31'b0, resp_err}, 32'd0);
    check("lw4_addr", addr_seen, 32'd1);

    run(1'b1, 2'b00, 1'b0, 32'h09, 32'h123456AB, lat, we_cnt, we_at, addr_seen);
    check("sb9_lat", lat, 32'd3);
    check("sb9_we_cnt", we_cnt, 32'd1);
    check("sb9_we_at", we_at, 32'd2);
    check("sb9_rdata", resp_rdata, 32'd0);
    check("sb9_mem2", mem[2], 32'h0000AB03);
    run(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, lat, we_cnt, we_at, addr_seen);
    check("lb9", resp_rdata, 32'hFFFFFFAB);
    run(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, lat, we_cnt, we_at, addr_seen);
    check("lbu9", resp_rdata, 32'h000000AB);

    run(1'b1, 2'b01, 1'b0, 32'h0E, 32'h00008001, lat, we_cnt, we_at, addr_seen);
    check("shE_lat", lat, 32'd3);
    check("shE_mem3", mem[3], 32'h80010004);
    run(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, lat, we_cnt, we_at, addr_seen);
    check("lhE", resp_rdata, 32'hFFFF8001);
    run(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, lat, we_cnt, we_at, addr_seen);
    check("lhuE", resp_rdata, 32'h00008001);

    run(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, lat, we_cnt, we_at, addr_seen);
    check("sw14_lat", lat, 32'd2);
    check("sw14_we_at", we_at, 32'd1);
    check("sw14_mem5", mem[5], 32'hDEADBEEF);
    run(1'b0, 2'b10, 1'b1, 32'h14, 32'h0, lat, we_cnt, we_at, addr_seen);
    check("lw14", resp_rdata, 32'hDEADBEEF);

    run(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, we_cnt, we_at, addr_seen);
    check("lw6_lat", lat, 32'd1);
    check("lw6_err", {31'b0, resp_err}, 32'd1);
    check("lw6_rdata", resp_rdata, 32'd0);
    run(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFFFFFF, lat, we_cnt, we_at, addr_seen);
    check("sh3_lat", lat, 32'd1);
    check("sh3_err", {31'b0, resp_err}, 32'd1);
    check("sh3_we_cnt", we_cnt, 32'd0);
    run(1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF, lat, we_cnt, we_at, addr_seen);
    check("sz11_lat", lat, 32'd1);
    check("sz11_err", {31'b0, resp_err}, 32'd1);
    check("sz11_we_cnt", we_cnt, 32'd0);
    check("err_mem0", mem[0], 32'd1);
    check("err_mem1", mem[1], 32'd2);

    run(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat, we_cnt, we_at, addr_seen);
`ifdef MEM_BOUNDS_CHECK_EN
    check("lw80_lat", lat, 32'd1);
    check("lw80_err", {31'b0, resp_err}, 32'd1);
    check("lw80_rdata", resp_rdata, 32'd0);
`else
    check("lw80_lat", lat, 32'd2);
    check("lw80_err", {31'b0, resp_err}, 32'd0);
    check("lw80_addr", addr_seen, 32'd0);
    check("lw80_rdata", resp_rdata, 32'd1);
`endif

    // Abort a sub-word store in its write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h00; req_wdata = 32'h000000FF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_we_before", {31'b0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("abort_we_async", {31'b0, mem_we}, 32'd0);
    saw_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("abort_no_resp", {31'b0, saw_resp}, 32'd0);
    check("abort_mem0", mem[0], 32'd1);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    run(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, lat, we_cnt, we_at, addr_seen);
    check("post_abort_lat", lat, 32'd2);
    check("post_abort_rdata", resp_rdata, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
